// File: rtl/instr_fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_queue_pkg
// Description : Shared constants and helpers for the dual-issue fetch queue
//               and its consumer (relayer_unit).
// Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_queue_pkg;

    localparam int IW_DEFAULT    = 16;
    localparam int AW_DEFAULT    = 8;
    localparam int DEPTH_DEFAULT = 8;

    // Instruction presented downstream whenever a slot holds no real entry.
    // relayer_unit treats this encoding as a no-op.
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    // Dequeue amounts the queue can honour in one cycle.
    localparam logic [1:0] DEQ_NONE = 2'd0;
    localparam logic [1:0] DEQ_ONE  = 2'd1;
    localparam logic [1:0] DEQ_TWO  = 2'd2;

    // Number of entries consumed this cycle. A redirect discards the whole
    // queue through the flush path, so it consumes nothing explicitly.
    function automatic logic [1:0] deq_amount(
        input logic redirect,
        input logic stall,
        input logic single,
        input logic has_one,
        input logic has_two
    );
        logic [1:0] amt;
        amt = DEQ_NONE;
        if (redirect || stall) begin
            amt = DEQ_NONE;
        end else if (single) begin
            amt = has_one ? DEQ_ONE : DEQ_NONE;
        end else if (has_two) begin
            amt = DEQ_TWO;
        end else if (has_one) begin
            amt = DEQ_ONE;
        end
        return amt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_queue_pair_fifo.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_queue_pair_fifo
// Description : DEPTH-entry circular buffer of {pc, instr} with a 2-wide
//               write port, 0..2 entry dequeue, occupancy count and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_queue_pair_fifo #(
    parameter  int DEPTH = 8,
    parameter  int AW    = 8,
    parameter  int IW    = 16,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          enq,
    input  logic [AW-1:0] wr_pc,
    input  logic [IW-1:0] wr_instr0,
    input  logic [IW-1:0] wr_instr1,
    input  logic [1:0]    deq_cnt,
    output logic [CW-1:0] count,
    output logic [AW-1:0] head_pc,
    output logic [IW-1:0] head0_instr,
    output logic [IW-1:0] head1_instr
);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] head_p1;
    logic [PW-1:0] tail_p1;

    logic [AW-1:0] pc_mem_q    [DEPTH];
    logic [AW-1:0] pc_mem_d    [DEPTH];
    logic [IW-1:0] instr_mem_q [DEPTH];
    logic [IW-1:0] instr_mem_d [DEPTH];

    // DEPTH is a power of two, so pointer arithmetic wraps by overflow.
    assign head_p1 = head_q + PW'(1);
    assign tail_p1 = tail_q + PW'(1);

    // Next-state for pointers, occupancy and storage; flush beats everything.
    always_comb begin
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                pc_mem_d[tail_q]     = wr_pc;
                instr_mem_d[tail_q]  = wr_instr0;
                pc_mem_d[tail_p1]    = wr_pc + AW'(1);
                instr_mem_d[tail_p1] = wr_instr1;
                tail_d               = tail_q + PW'(2);
            end
            head_d  = head_q + PW'(deq_cnt);
            count_d = count_q + (enq ? CW'(2) : CW'(0)) - CW'(deq_cnt);
        end
    end

    // Control state, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        pc_mem_q    <= pc_mem_d;
        instr_mem_q <= instr_mem_d;
    end

    // Oldest two entries; the second index wraps so a straddling pair reads
    // correctly.
    assign count       = count_q;
    assign head_pc     = pc_mem_q[head_q];
    assign head0_instr = instr_mem_q[head_q];
    assign head1_instr = instr_mem_q[head_p1];

endmodule
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_queue
// Description : Dual-issue fetch stage. Holds the fetch PC, enqueues two
//               consecutive instructions per cycle when room allows, and
//               presents the two oldest entries to relayer_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int IW    = IW_DEFAULT,
    parameter int AW    = AW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_rdata0,
    input  logic [IW-1:0] imem_rdata1,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    input  logic          stall_in,
    input  logic          single_in,
    output logic [IW-1:0] instr1_o,
    output logic [IW-1:0] instr2_o,
    output logic          valid1_o,
    output logic          valid2_o,
    output logic [AW-1:0] pc1_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [AW-1:0] pc_q, pc_d;
    logic [CW-1:0] count;
    logic [CW-1:0] free_slots;
    logic          has_one;
    logic          has_two;
    logic          enq;
    logic [1:0]    deq_cnt;
    logic [AW-1:0] head_pc;
    logic [IW-1:0] head0_instr;
    logic [IW-1:0] head1_instr;

    assign has_one    = (count != '0);
    assign has_two    = (count >= CW'(2));
    assign free_slots = CW'(DEPTH) - count;

    // Enqueue decision uses the pre-dequeue occupancy so room is guaranteed
    // regardless of what relayer_unit consumes; a redirect suppresses it.
    always_comb begin
        enq     = 1'b0;
        deq_cnt = deq_amount(redirect_valid, stall_in, single_in, has_one, has_two);
        if (!redirect_valid && (free_slots >= CW'(2))) begin
            enq = 1'b1;
        end
    end

    // Fetch PC: redirect target wins, otherwise advance by a pair on enqueue.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (enq) begin
            pc_d = pc_q + AW'(2);
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign imem_addr = pc_q;

    instr_fetch_queue_pair_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .IW    (IW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush       (redirect_valid),
        .enq         (enq),
        .wr_pc       (pc_q),
        .wr_instr0   (imem_rdata0),
        .wr_instr1   (imem_rdata1),
        .deq_cnt     (deq_cnt),
        .count       (count),
        .head_pc     (head_pc),
        .head0_instr (head0_instr),
        .head1_instr (head1_instr)
    );

    // Outputs come from registered queue state only; stall/single never reach
    // them combinationally, which breaks the loop through relayer_unit.
    always_comb begin
        valid1_o = has_one;
        valid2_o = has_two;
        instr1_o = has_one ? head0_instr : IW'(NOP_INSTR);
        instr2_o = has_two ? head1_instr : IW'(NOP_INSTR);
        pc1_o    = has_one ? head_pc : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_queue
// Description : Directed self-checking bench for instr_fetch_queue. Instance
//               a uses DEPTH=8, instance b uses DEPTH=4 for wrap checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic        stall_in = 1'b0;
    logic        single_in = 1'b0;

    logic [15:0] imem [256];

    logic [7:0]  addr_a, addr_a_p1;
    logic [15:0] rd0_a, rd1_a, i1_a, i2_a;
    logic        v1_a, v2_a;
    logic [7:0]  pc1_a;

    logic [7:0]  addr_b, addr_b_p1;
    logic [15:0] rd0_b, rd1_b, i1_b, i2_b;
    logic        v1_b, v2_b;
    logic [7:0]  pc1_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign addr_a_p1 = addr_a + 8'd1;
    assign addr_b_p1 = addr_b + 8'd1;
    assign rd0_a = imem[addr_a];
    assign rd1_a = imem[addr_a_p1];
    assign rd0_b = imem[addr_b];
    assign rd1_b = imem[addr_b_p1];

    instr_fetch_queue #(.IW(16), .AW(8), .DEPTH(8)) dut_a (
        .clk(clk), .rst(rst), .imem_addr(addr_a), .imem_rdata0(rd0_a), .imem_rdata1(rd1_a),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall_in(stall_in), .single_in(single_in),
        .instr1_o(i1_a), .instr2_o(i2_a), .valid1_o(v1_a), .valid2_o(v2_a), .pc1_o(pc1_a)
    );

    instr_fetch_queue #(.IW(16), .AW(8), .DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .imem_addr(addr_b), .imem_rdata0(rd0_b), .imem_rdata1(rd1_b),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall_in(stall_in), .single_in(single_in),
        .instr1_o(i1_b), .instr2_o(i2_b), .valid1_o(v1_b), .valid2_o(v2_b), .pc1_o(pc1_b)
    );

    // Output consistency on every falling edge while out of reset.
    always @(negedge clk) begin
        if (!rst) begin
            n_cmp++;
            if ((v2_a && !v1_a) || (!v1_a && (i1_a !== 16'h0000 || pc1_a !== 8'h00))
                || (!v2_a && i2_a !== 16'h0000)) begin
                n_err++;
                $display("FAIL inv_a v1=%b v2=%b i1=%h i2=%h pc1=%h required valid2->valid1, NOP/0 when invalid",
                         v1_a, v2_a, i1_a, i2_a, pc1_a);
            end
            n_cmp++;
            if ((v2_b && !v1_b) || (!v1_b && (i1_b !== 16'h0000 || pc1_b !== 8'h00))
                || (!v2_b && i2_b !== 16'h0000)) begin
                n_err++;
                $display("FAIL inv_b v1=%b v2=%b i1=%h i2=%h pc1=%h required valid2->valid1, NOP/0 when invalid",
                         v1_b, v2_b, i1_b, i2_b, pc1_b);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        redirect_valid = 1'b0;
        stall_in       = 1'b0;
        single_in      = 1'b0;
        rst            = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({i1_a, i2_a} !== 32'h0) begin
            n_err++;
            $display("FAIL reset_instr got %h/%h required 0000/0000", i1_a, i2_a);
        end
        n_cmp++;
        if ({v1_a, v2_a} !== 2'b00 || pc1_a !== 8'h00) begin
            n_err++;
            $display("FAIL reset_valid got v=%b%b pc1=%h required v=00 pc1=00", v1_a, v2_a, pc1_a);
        end
        n_cmp++;
        if (addr_a !== 8'h00) begin
            n_err++;
            $display("FAIL reset_addr got %h required 00", addr_a);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({i1_a, i2_a, v1_a, v2_a, pc1_a} !== {16'h1000, 16'h1001, 2'b11, 8'h00}) begin
            n_err++;
            $display("FAIL reset_first got %h/%h v=%b%b pc1=%h required 1000/1001 v=11 pc1=00",
                     i1_a, i2_a, v1_a, v2_a, pc1_a);
        end
    endtask

    task automatic test_stream;
        logic [15:0] e1;
        logic [7:0]  epc;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            tick();
            epc = 8'(2 * k);
            e1  = 16'h1000 + 16'(2 * k);
            n_cmp++;
            if ({i1_a, i2_a, v1_a, v2_a, pc1_a, addr_a} !== {e1, e1 + 16'h1, 2'b11, epc, epc + 8'd2}) begin
                n_err++;
                $display("FAIL stream%0d got %h/%h v=%b%b pc1=%h addr=%h required %h/%h v=11 pc1=%h addr=%h",
                         k, i1_a, i2_a, v1_a, v2_a, pc1_a, addr_a, e1, e1 + 16'h1, epc, epc + 8'd2);
            end
        end
    endtask

    task automatic test_single;
        do_reset();
        tick();
        tick();
        n_cmp++;
        if ({i1_a, i2_a, pc1_a} !== {16'h1002, 16'h1003, 8'h02}) begin
            n_err++;
            $display("FAIL single_pre got %h/%h pc1=%h required 1002/1003 pc1=02", i1_a, i2_a, pc1_a);
        end
        single_in = 1'b1;
        tick();
        n_cmp++;
        if ({i1_a, i2_a, v1_a, v2_a, pc1_a} !== {16'h1003, 16'h1004, 2'b11, 8'h03}) begin
            n_err++;
            $display("FAIL single_1 got %h/%h v=%b%b pc1=%h required 1003/1004 v=11 pc1=03",
                     i1_a, i2_a, v1_a, v2_a, pc1_a);
        end
        tick();
        n_cmp++;
        if ({i1_a, i2_a, v1_a, v2_a, pc1_a} !== {16'h1004, 16'h1005, 2'b11, 8'h04}) begin
            n_err++;
            $display("FAIL single_2 got %h/%h v=%b%b pc1=%h required 1004/1005 v=11 pc1=04",
                     i1_a, i2_a, v1_a, v2_a, pc1_a);
        end
        single_in = 1'b0;
    endtask

    task automatic test_stall_full;
        logic [7:0] exp_addr [6];
        logic [7:0] res_addr [4];
        logic [15:0] e1;
        exp_addr = '{8'h04, 8'h06, 8'h08, 8'h08, 8'h08, 8'h08};
        res_addr = '{8'h08, 8'h0A, 8'h0C, 8'h0E};
        do_reset();
        tick();
        stall_in = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_cmp++;
            if ({i1_a, i2_a, v1_a, v2_a, pc1_a, addr_a} !== {16'h1000, 16'h1001, 2'b11, 8'h00, exp_addr[k]}) begin
                n_err++;
                $display("FAIL stall%0d got %h/%h v=%b%b pc1=%h addr=%h required 1000/1001 v=11 pc1=00 addr=%h",
                         k, i1_a, i2_a, v1_a, v2_a, pc1_a, addr_a, exp_addr[k]);
            end
        end
        stall_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            e1 = 16'h1002 + 16'(2 * k);
            n_cmp++;
            if ({i1_a, i2_a, v1_a, v2_a, addr_a} !== {e1, e1 + 16'h1, 2'b11, res_addr[k]}) begin
                n_err++;
                $display("FAIL resume%0d got %h/%h v=%b%b addr=%h required %h/%h v=11 addr=%h",
                         k, i1_a, i2_a, v1_a, v2_a, addr_a, e1, e1 + 16'h1, res_addr[k]);
            end
        end
    endtask

    task automatic test_redirect;
        do_reset();
        tick();
        stall_in       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        tick();
        redirect_valid = 1'b0;
        n_cmp++;
        if ({v1_a, v2_a, i1_a, i2_a, addr_a} !== {2'b00, 32'h0, 8'h40}) begin
            n_err++;
            $display("FAIL redir_flush got v=%b%b %h/%h addr=%h required v=00 0000/0000 addr=40",
                     v1_a, v2_a, i1_a, i2_a, addr_a);
        end
        tick();
        n_cmp++;
        if ({i1_a, i2_a, v1_a, v2_a, pc1_a, addr_a} !== {16'h1040, 16'h1041, 2'b11, 8'h40, 8'h42}) begin
            n_err++;
            $display("FAIL redir_target got %h/%h v=%b%b pc1=%h addr=%h required 1040/1041 v=11 pc1=40 addr=42",
                     i1_a, i2_a, v1_a, v2_a, pc1_a, addr_a);
        end
        stall_in = 1'b0;
    endtask

    task automatic test_pc_wrap;
        redirect_valid = 1'b1;
        redirect_pc    = 8'hFF;
        tick();
        redirect_valid = 1'b0;
        n_cmp++;
        if ({v1_a, v2_a, addr_a} !== {2'b00, 8'hFF}) begin
            n_err++;
            $display("FAIL wrap_flush got v=%b%b addr=%h required v=00 addr=ff", v1_a, v2_a, addr_a);
        end
        tick();
        n_cmp++;
        if ({i1_a, i2_a, v1_a, v2_a, pc1_a, addr_a} !== {16'h10FF, 16'h1000, 2'b11, 8'hFF, 8'h01}) begin
            n_err++;
            $display("FAIL wrap_pair got %h/%h v=%b%b pc1=%h addr=%h required 10ff/1000 v=11 pc1=ff addr=01",
                     i1_a, i2_a, v1_a, v2_a, pc1_a, addr_a);
        end
        single_in = 1'b1;
        tick();
        n_cmp++;
        if ({i1_a, i2_a, pc1_a} !== {16'h1000, 16'h1001, 8'h00}) begin
            n_err++;
            $display("FAIL wrap_single got %h/%h pc1=%h required 1000/1001 pc1=00", i1_a, i2_a, pc1_a);
        end
        single_in = 1'b0;
    endtask

    task automatic test_straddle;
        logic [15:0] e1;
        do_reset();
        tick();
        n_cmp++;
        if ({i1_b, i2_b, v1_b, v2_b, pc1_b} !== {16'h1000, 16'h1001, 2'b11, 8'h00}) begin
            n_err++;
            $display("FAIL d4_first got %h/%h v=%b%b pc1=%h required 1000/1001 v=11 pc1=00",
                     i1_b, i2_b, v1_b, v2_b, pc1_b);
        end
        single_in = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            e1 = 16'h1000 + 16'(k);
            n_cmp++;
            if ({i1_b, i2_b, v1_b, v2_b, pc1_b} !== {e1, e1 + 16'h1, 2'b11, 8'(k)}) begin
                n_err++;
                $display("FAIL d4_single%0d got %h/%h v=%b%b pc1=%h required %h/%h v=11 pc1=%h",
                         k, i1_b, i2_b, v1_b, v2_b, pc1_b, e1, e1 + 16'h1, 8'(k));
            end
        end
        single_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 16'h1000 + 16'(i);
        test_reset();
        test_stream();
        test_single();
        test_stall_full();
        test_redirect();
        test_pc_wrap();
        test_straddle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
